// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               FSM state encoding, default reset PC, instruction width,
//               canonical NOP and PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with flush. The head entry is
//               visible combinationally. A push and a pop in the same cycle
//               are both honoured, including when the FIFO is full.
// Ports       : clk, rst_n (async active-low), flush, push/push_data,
//               pop, head, full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : RV32 fetch front end. Owns the PC, issues in-order word reads
//               to instruction memory, buffers returned words in a prefetch
//               FIFO and hands them to decode. Handles redirects (flush +
//               drop of stale responses) and a sticky misaligned-target fault.
// Ports       : clk, rst_n, imem_req_*, imem_rsp_*, dec_*, redirect_*,
//               fetch_fault
// Options     : FETCH_PERF_CNT_EN - adds saturating perf_fetched and
//               perf_flushed counters as output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + XLEN;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;

    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic             run;
    logic             rsp_fire;
    logic             rsp_drop;
    logic             redir_ok;
    logic             redir_bad;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    assign run       = (state == RUN);
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_fire  = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop  = rsp_fire && (drop_cnt != '0);
    assign redir_ok  = run && redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = run && redirect_valid && (redirect_target[1:0] != 2'b00);
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

    // Every outstanding request has a reserved FIFO slot, so a response can
    // always be pushed without overflow.
    assign imem_req_valid = run && !redirect_valid && !fifo_full &&
                            (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign dec_valid    = run && !fifo_empty;
    // A redirect wins over a pop: decode already consumed that instruction.
    assign pop          = dec_valid && dec_ready && !redirect_valid;
    assign push         = rsp_fire && !rsp_drop && run && !redirect_valid;

    assign dec_instr    = dec_valid ? fifo_head[ENTRY_W-1:XLEN] : '0;
    assign dec_pc       = dec_valid ? fifo_head[XLEN-1:0] : '0;
    assign dec_pc_plus4 = dec_valid ? (fifo_head[XLEN-1:0] + XLEN'(PC_STEP)) : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redir_ok),
        .push      (push),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_fault <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN: begin
                    if (redir_bad) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= BOOT;
            endcase

            case ({accept, rsp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            // Everything still in flight after this cycle is wrong-path.
            if (redir_ok) begin
                drop_cnt <= outstanding - (rsp_fire ? CNT_W'(1) : CNT_W'(0));
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end

            if (redir_ok) begin
                fetch_pc <= redirect_target;
            end else if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end

            if (redir_ok) begin
                rsp_pc <= redirect_target;
            end else if (push) begin
                rsp_pc <= rsp_pc + XLEN'(PC_STEP);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] fetched_sum;
    logic [32:0] flushed_sum;

    assign fetched_sum = {1'b0, perf_fetched} + 33'(pop);
    assign flushed_sum = {1'b0, perf_flushed} +
                         (redir_ok ? 33'(fifo_count) : 33'd0) +
                         33'(rsp_fire && run && !push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
            perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench. u_dut0 (RESET_PC=0, depth 4)
//               sits behind a queue-based memory that can be stalled;
//               u_dut1 (RESET_PC=0xFFFF_FFF8, depth 2) sits behind a fixed
//               1-cycle memory. Instruction word returned = ~address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_fault;
    logic        mem_stall;

    logic        req_valid1, req_ready1, rsp_valid1;
    logic [31:0] req_addr1, rsp_data1;
    logic        dec_valid1, dec_ready1;
    logic [31:0] dec_instr1, dec_pc1, dec_pc_plus41;
    logic        redirect_valid1;
    logic [31:0] redirect_target1;
    logic        fetch_fault1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_fetched1, perf_flushed1;
`endif

    int tests = 0;
    int fails = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid1), .imem_req_ready(req_ready1), .imem_req_addr(req_addr1),
        .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data1),
        .dec_valid(dec_valid1), .dec_ready(dec_ready1), .dec_instr(dec_instr1),
        .dec_pc(dec_pc1), .dec_pc_plus4(dec_pc_plus41),
        .redirect_valid(redirect_valid1), .redirect_target(redirect_target1),
        .fetch_fault(fetch_fault1)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched1), .perf_flushed(perf_flushed1)
`endif
    );

    // Memory for u_dut0: in-order queue, answers one request per cycle
    // starting the cycle after acceptance unless stalled.
    logic [31:0] mem_q [$];
    logic [31:0] mem_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (req_valid && req_ready) mem_q.push_back(req_addr);
            if (!mem_stall && mem_q.size() != 0) begin
                mem_a = mem_q.pop_front();
                rsp_valid <= 1'b1;
                rsp_data  <= ~mem_a;
            end else begin
                rsp_valid <= 1'b0;
                rsp_data  <= '0;
            end
        end
    end

    // Memory for u_dut1: fixed 1-cycle latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid1 <= 1'b0;
            rsp_data1  <= '0;
        end else begin
            rsp_valid1 <= req_valid1 && req_ready1;
            rsp_data1  <= ~req_addr1;
        end
    end

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        dec_ready = 1'b1; req_ready = 1'b1; mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        dec_ready = 1'b1; req_ready = 1'b1; mem_stall = 1'b0;
        @(negedge clk);
        tests++; if ({req_valid, dec_valid, fetch_fault} !== 3'b000) begin fails++;
            $display("FAIL reset_flags: got %b expected 000", {req_valid, dec_valid, fetch_fault}); end
        tests++; if (req_addr !== 32'h0) begin fails++;
            $display("FAIL reset_addr: got %h expected 00000000", req_addr); end
        tests++; if ({dec_instr, dec_pc, dec_pc_plus4} !== 96'h0) begin fails++;
            $display("FAIL reset_dec: got %h %h %h expected zeros", dec_instr, dec_pc, dec_pc_plus4); end
        tests++; if (req_addr1 !== 32'hFFFF_FFF8) begin fails++;
            $display("FAIL reset_addr1: got %h expected fffffff8", req_addr1); end
        tests++; if ({req_valid1, dec_valid1, dec_pc_plus41} !== 34'h0) begin fails++;
            $display("FAIL reset_dut1: got %b %b %h expected 0 0 0", req_valid1, dec_valid1, dec_pc_plus41); end
    endtask

    task automatic test_fetch_stream;
        apply_reset();
        @(negedge clk);
        tests++; if ({req_valid, req_addr, dec_valid} !== {1'b1, 32'h0, 1'b0}) begin fails++;
            $display("FAIL stream_first_req: got %b %h %b expected 1 00000000 0", req_valid, req_addr, dec_valid); end
        @(negedge clk);
        tests++; if ({req_valid, req_addr} !== {1'b1, 32'h4}) begin fails++;
            $display("FAIL stream_second_req: got %b %h expected 1 00000004", req_valid, req_addr); end
        @(negedge clk);
        tests++; if ({dec_valid, dec_pc, dec_pc_plus4, dec_instr} !== {1'b1, 32'h0, 32'h4, 32'hFFFF_FFFF}) begin fails++;
            $display("FAIL stream_first_dec: got %b %h %h %h expected 1 00000000 00000004 ffffffff",
                     dec_valid, dec_pc, dec_pc_plus4, dec_instr); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests++; if ({dec_valid, dec_pc} !== {1'b1, 32'(4 * k)}) begin fails++;
                $display("FAIL stream_rate[%0d]: got %b %h expected 1 %h", k, dec_valid, dec_pc, 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure;
        apply_reset();
        dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        tests++; if ({req_valid, req_addr, dec_valid, dec_pc} !== {1'b0, 32'h10, 1'b1, 32'h0}) begin fails++;
            $display("FAIL bp_hold: got %b %h %b %h expected 0 00000010 1 00000000", req_valid, req_addr, dec_valid, dec_pc); end
        dec_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests++; if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 32'(4 * k), ~32'(4 * k)}) begin fails++;
                $display("FAIL bp_order[%0d]: got %b %h %h expected 1 %h", k, dec_valid, dec_pc, dec_instr, 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect_outstanding;
        int n;
        apply_reset();
        mem_stall = 1'b1;
        repeat (3) @(negedge clk);
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0; mem_stall = 1'b0; req_ready = 1'b1;
        #1;
        tests++; if ({dec_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h100}) begin fails++;
            $display("FAIL redir_resume: got %b %b %h expected 0 1 00000100", dec_valid, req_valid, req_addr); end
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        tests++; if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 32'h100, ~32'h100}) begin fails++;
            $display("FAIL redir_first: got %b %h %h expected 1 00000100 fffffeff", dec_valid, dec_pc, dec_instr); end
        @(negedge clk);
        tests++; if ({dec_valid, dec_pc} !== {1'b1, 32'h104}) begin fails++;
            $display("FAIL redir_second: got %b %h expected 1 00000104", dec_valid, dec_pc); end
    endtask

    task automatic test_redirect_collision;
        int n;
        apply_reset();
        n = 0;
        while (!(dec_valid && dec_pc == 32'h10) && n < 20) begin @(negedge clk); n++; end
        tests++; if ({dec_valid, dec_pc, rsp_valid} !== {1'b1, 32'h10, 1'b1}) begin fails++;
            $display("FAIL coll_setup: got %b %h %b expected 1 00000010 1", dec_valid, dec_pc, rsp_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (dec_valid !== 1'b0) begin fails++;
            $display("FAIL coll_flush: got %b expected 0", dec_valid); end
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        tests++; if ({dec_valid, dec_pc} !== {1'b1, 32'h200}) begin fails++;
            $display("FAIL coll_target: got %b %h expected 1 00000200", dec_valid, dec_pc); end
        @(negedge clk);
        tests++; if ({dec_valid, dec_pc} !== {1'b1, 32'h204}) begin fails++;
            $display("FAIL coll_next: got %b %h expected 1 00000204", dec_valid, dec_pc); end
    endtask

    task automatic test_misaligned;
        int n;
        apply_reset();
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        redirect_valid = 1'b1; redirect_target = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++; if ({fetch_fault, req_valid, dec_valid} !== 3'b100) begin fails++;
                $display("FAIL fault_state[%0d]: got %b expected 100", k, {fetch_fault, req_valid, dec_valid}); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (fetch_fault !== 1'b0) begin fails++;
            $display("FAIL fault_clear: got %b expected 0", fetch_fault); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin fails++;
            $display("FAIL fault_restart: got %b %h expected 1 00000000", req_valid, req_addr); end
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        tests++; if ({dec_valid, dec_pc} !== {1'b1, 32'h0}) begin fails++;
            $display("FAIL fault_first_dec: got %b %h expected 1 00000000", dec_valid, dec_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] pcs [3];
        logic [31:0] p4s [3];
        int got, n;
        apply_reset();
        @(negedge clk);
        tests++; if ({req_valid1, req_addr1} !== {1'b1, 32'hFFFF_FFF8}) begin fails++;
            $display("FAIL wrap_first_req: got %b %h expected 1 fffffff8", req_valid1, req_addr1); end
        got = 0; n = 0;
        for (int i = 0; i < 3; i++) begin pcs[i] = 'x; p4s[i] = 'x; end
        while (got < 3 && n < 30) begin
            @(negedge clk); n++;
            if (dec_valid1) begin pcs[got] = dec_pc1; p4s[got] = dec_pc_plus41; got++; end
        end
        tests++; if ({pcs[0], pcs[1], pcs[2]} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0}) begin fails++;
            $display("FAIL wrap_order: got %h %h %h expected fffffff8 fffffffc 00000000", pcs[0], pcs[1], pcs[2]); end
        tests++; if ({p4s[0], p4s[1]} !== {32'hFFFF_FFFC, 32'h0}) begin fails++;
            $display("FAIL wrap_plus4: got %h %h expected fffffffc 00000000", p4s[0], p4s[1]); end
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        dec_ready = 1'b1; req_ready = 1'b1; mem_stall = 1'b0;
        req_ready1 = 1'b1; dec_ready1 = 1'b1;
        redirect_valid1 = 1'b0; redirect_target1 = '0;
        test_reset();
        test_fetch_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_collision();
        test_misaligned();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
